// File: rtl/rom_dl_loader_if.sv
// Host download stream in, ROM write-port bus out.
// The host side (master) drives DL_*; the loader (slave) drives ROM_*.
interface rom_dl_loader_if #(
    parameter int AW   = 16,
    parameter int RSH  = 14,
    parameter int NREG = 4
);
    logic            DL_ACT;
    logic [7:0]      DL_INDEX;
    logic            DL_WR;
    logic [AW-1:0]   DL_ADDR;
    logic [7:0]      DL_DATA;
    logic [RSH-1:0]  ROM_AD;
    logic [7:0]      ROM_DI;
    logic [NREG-1:0] ROM_WE;

    // DL_WR is a one-cycle strobe with no back-pressure: every strobe seen while
    // loading is taken, and ROM_WE is a one-cycle write pulse one cycle later.
    modport master (
        output DL_ACT, DL_INDEX, DL_WR, DL_ADDR, DL_DATA,
        input  ROM_AD, ROM_DI, ROM_WE
    );

    modport slave (
        input  DL_ACT, DL_INDEX, DL_WR, DL_ADDR, DL_DATA,
        output ROM_AD, ROM_DI, ROM_WE
    );
endinterface

// File: rtl/rom_dl_loader.sv
// Download loader: decodes host bytes into region ROM writes, tracks progress,
// and releases the core from reset once this index has finished loading.
module rom_dl_loader #(
    parameter int AW   = 16,
    parameter int RSH  = 14,
    parameter int NREG = 4,
    parameter int IDX  = 0
) (
    input  logic            CLK,
    input  logic            RESET_N,
    rom_dl_loader_if.slave  bus,
    output logic            CORE_RST,
    output logic            READY,
    output logic            ERR,
    output logic [AW:0]     BYTES,
    output logic [15:0]     CSUM,
    output logic [1:0]      DBG_STATE
);
    localparam int RW = AW - RSH;
    localparam logic [7:0]  IDX_L  = 8'(IDX);
    localparam logic [RW:0] NREG_L = (RW + 1)'(NREG);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q;
    logic            active_q;
    logic [RSH-1:0]  rom_ad_q;
    logic [7:0]      rom_di_q;
    logic [NREG-1:0] rom_we_q;
    logic            ready_q;
    logic            core_rst_q;
    logic            err_q;
    logic [AW:0]     bytes_q, bytes_d;
    logic [15:0]     csum_q, csum_d;

    logic            active;
    logic            rise;
    logic [RW-1:0]   region;
    logic            in_range;
    logic [NREG-1:0] we_onehot;

    // Another index on the bus counts as inactive: a different loader owns it.
    assign active   = bus.DL_ACT && (bus.DL_INDEX == IDX_L);
    assign rise     = active && !active_q;
    assign region   = bus.DL_ADDR[AW-1:RSH];
    assign in_range = ({1'b0, region} < NREG_L);

    always_comb begin
        we_onehot = '0;
        if (in_range) we_onehot[region] = 1'b1;
    end

    assign bytes_d = (bytes_q == '1) ? bytes_q : bytes_q + (AW + 1)'(1);
    assign csum_d  = csum_q + {8'd0, bus.DL_DATA};

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            active_q   <= 1'b0;
            rom_ad_q   <= '0;
            rom_di_q   <= '0;
            rom_we_q   <= '0;
            ready_q    <= 1'b0;
            core_rst_q <= 1'b1;
            err_q      <= 1'b0;
            bytes_q    <= '0;
            csum_q     <= '0;
        end else begin
            active_q <= active;
            rom_we_q <= '0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (rise) begin
                        state_q    <= S_LOAD;
                        bytes_q    <= '0;
                        csum_q     <= '0;
                        err_q      <= 1'b0;
                        ready_q    <= 1'b0;
                        core_rst_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // A strobe in the cycle Active drops is still taken; FLUSH retires it.
                    if (bus.DL_WR) begin
                        rom_ad_q <= bus.DL_ADDR[RSH-1:0];
                        rom_di_q <= bus.DL_DATA;
                        rom_we_q <= we_onehot;
                        bytes_q  <= bytes_d;
                        csum_q   <= csum_d;
                        if (!in_range) err_q <= 1'b1;
                    end
                    if (!active) state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    state_q    <= S_DONE;
                    ready_q    <= 1'b1;
                    core_rst_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ROM_AD = rom_ad_q;
    assign bus.ROM_DI = rom_di_q;
    assign bus.ROM_WE = rom_we_q;
    assign CORE_RST   = core_rst_q;
    assign READY      = ready_q;
    assign ERR        = err_q;
    assign BYTES      = bytes_q;
    assign CSUM       = csum_q;
    assign DBG_STATE  = state_q;
endmodule

// File: tb/tb_rom_dl_loader.sv
// Bench for rom_dl_loader: two instances (4 and 3 regions) fed the same stream,
// compared every cycle against a behavioural model of the download rules.
module tb_rom_dl_loader;
  localparam int AW  = 16;
  localparam int RSH = 14;
  localparam int IDX = 0;
  localparam int W   = 4 + RSH + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_dl_loader_if #(.AW(AW), .RSH(RSH), .NREG(4)) if_a ();
  rom_dl_loader_if #(.AW(AW), .RSH(RSH), .NREG(3)) if_b ();

  logic        a_core_rst, a_ready, a_err, b_core_rst, b_ready, b_err;
  logic [AW:0] a_bytes, b_bytes;
  logic [15:0] a_csum, b_csum;
  logic [1:0]  a_state, b_state;

  rom_dl_loader #(.AW(AW), .RSH(RSH), .NREG(4), .IDX(IDX)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .bus(if_a),
    .CORE_RST(a_core_rst), .READY(a_ready), .ERR(a_err),
    .BYTES(a_bytes), .CSUM(a_csum), .DBG_STATE(a_state)
  );

  rom_dl_loader #(.AW(AW), .RSH(RSH), .NREG(3), .IDX(IDX)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .bus(if_b),
    .CORE_RST(b_core_rst), .READY(b_ready), .ERR(b_err),
    .BYTES(b_bytes), .CSUM(b_csum), .DBG_STATE(b_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  bit          m_load, m_flush, m_ready, m_prev;
  bit          m_err_a, m_err_b;
  logic [AW:0] m_bytes;
  logic [15:0] m_sum;
  logic [RSH-1:0] m_ad;
  logic [7:0]  m_di;
  logic [3:0]  m_we_a;
  logic [2:0]  m_we_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_load = 0; m_flush = 0; m_ready = 0; m_prev = 0;
    m_err_a = 0; m_err_b = 0;
    m_bytes = '0; m_sum = '0; m_ad = '0; m_di = '0;
    m_we_a = '0; m_we_b = '0;
    exp_q.delete();
  endtask

  task automatic compare_outputs();
    logic [W-1:0] got_a;
    got_a = {if_a.ROM_WE, if_a.ROM_AD, if_a.ROM_DI};
    if (if_a.ROM_WE != 4'd0) begin
      if (exp_q.size() == 0) check("a_unexpected_write", got_a, '0);
      else check("a_write_order", got_a, exp_q.pop_front());
    end
    check("a_rom_bus", got_a, {m_we_a, m_ad, m_di});
    check("b_rom_bus", {if_b.ROM_WE, if_b.ROM_AD, if_b.ROM_DI}, {m_we_b, m_ad, m_di});
    check("a_status", {a_core_rst, a_ready, a_err}, {!m_ready, m_ready, m_err_a});
    check("b_status", {b_core_rst, b_ready, b_err}, {!m_ready, m_ready, m_err_b});
    check("a_bytes", a_bytes, m_bytes);
    check("b_bytes", b_bytes, m_bytes);
    check("a_csum", a_csum, m_sum);
    check("b_csum", b_csum, m_sum);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit act, input logic [7:0] idx, input bit wr,
                       input logic [15:0] addr, input logic [7:0] data);
    if_a.DL_ACT = act; if_a.DL_INDEX = idx; if_a.DL_WR = wr; if_a.DL_ADDR = addr; if_a.DL_DATA = data;
    if_b.DL_ACT = act; if_b.DL_INDEX = idx; if_b.DL_WR = wr; if_b.DL_ADDR = addr; if_b.DL_DATA = data;
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input bit act, input logic [7:0] idx, input bit wr,
                      input logic [15:0] addr, input logic [7:0] data);
    bit active, rise;
    int region;
    drive(act, idx, wr, addr, data);
    active = act && (idx == 8'(IDX));
    rise   = active && !m_prev;
    m_we_a = '0;
    m_we_b = '0;
    if (m_load) begin
      if (wr) begin
        region  = int'(addr) / (1 << RSH);
        m_bytes = (m_bytes == '1) ? m_bytes : m_bytes + 1'b1;
        m_sum   = m_sum + 16'(data);
        m_ad    = addr[RSH-1:0];
        m_di    = data;
        if (region < 4) m_we_a = 4'(1 << region); else m_err_a = 1;
        if (region < 3) m_we_b = 3'(1 << region); else m_err_b = 1;
        if (m_we_a != 0) exp_q.push_back({m_we_a, m_ad, m_di});
      end
      if (!active) begin m_load = 0; m_flush = 1; end
    end else if (m_flush) begin
      m_flush = 0;
      m_ready = 1;
    end else if (rise) begin
      m_load = 1; m_bytes = '0; m_sum = '0; m_err_a = 0; m_err_b = 0; m_ready = 0;
    end
    m_prev = active;
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'(IDX), 1'b0, 16'h0, 8'h0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    drive(1'b0, 8'(IDX), 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    model_reset();
    compare_outputs();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit wr;
    logic [7:0] idx;
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'(IDX), 1'b0, 16'h0, 8'h0);
    #1;

    // Reset and idle: outputs at reset values.
    do_reset(2);
    idle(10);
    check("t1_core_rst", a_core_rst, 1'b1);
    check("t1_bytes", a_bytes, '0);

    // Three regions back-to-back.
    step(1'b1, 8'(IDX), 1'b0, 16'h0, 8'h0);
    step(1'b1, 8'(IDX), 1'b1, 16'h0000, 8'h12);
    step(1'b1, 8'(IDX), 1'b1, 16'h4001, 8'h34);
    step(1'b1, 8'(IDX), 1'b1, 16'hC3FF, 8'h56);
    step(1'b0, 8'(IDX), 1'b0, 16'h0, 8'h0);
    idle(3);
    check("t2_bytes", a_bytes, 17'd3);
    check("t2_csum", a_csum, 16'h009C);
    check("t2_ready", a_ready, 1'b1);

    // Out-of-range region on the 3-region instance.
    step(1'b1, 8'(IDX), 1'b0, 16'h0, 8'h0);
    step(1'b1, 8'(IDX), 1'b1, 16'hC000, 8'hFF);
    step(1'b0, 8'(IDX), 1'b0, 16'h0, 8'h0);
    idle(2);
    check("t3_err_b", b_err, 1'b1);
    check("t3_err_a", a_err, 1'b0);
    check("t3_csum_b", b_csum, 16'h00FF);

    // Last strobe in the cycle DL_ACT falls.
    step(1'b1, 8'(IDX), 1'b0, 16'h0, 8'h0);
    step(1'b1, 8'(IDX), 1'b1, 16'h1234, 8'hA5);
    step(1'b0, 8'(IDX), 1'b1, 16'h8765, 8'h5A);
    check("t4_we", if_a.ROM_WE, 4'b0100);
    check("t4_ready_early", a_ready, 1'b0);
    idle(1);
    check("t4_ready", a_ready, 1'b1);
    idle(2);

    // Foreign index owns the stream.
    do_reset(1);
    for (int i = 0; i < 16; i++)
      step(1'b1, 8'(IDX + 1), 1'b1, 16'($urandom), 8'($urandom));
    check("t5_bytes", a_bytes, '0);
    check("t5_ready", a_ready, 1'b0);
    idle(2);

    // Reset in the middle of a load, then restart.
    step(1'b1, 8'(IDX), 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'(IDX), 1'b1, 16'($urandom), 8'($urandom));
    do_reset(1);
    check("t6_core_rst", a_core_rst, 1'b1);
    check("t6_bytes", a_bytes, '0);
    step(1'b1, 8'(IDX), 1'b0, 16'h0, 8'h0);
    step(1'b1, 8'(IDX), 1'b1, 16'h0010, 8'h07);
    check("t6_restart_bytes", a_bytes, 17'd1);
    check("t6_restart_csum", a_csum, 16'h0007);
    step(1'b0, 8'(IDX), 1'b0, 16'h0, 8'h0);
    idle(2);

    // Random downloads with gaps, stray strobes and occasional foreign index.
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++)
        step(1'b0, 8'(IDX), 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      step(1'b1, 8'(IDX), 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      n = $urandom_range(3, 24);
      for (int i = 0; i < n; i++) begin
        wr  = 1'($urandom_range(0, 1));
        idx = ($urandom_range(0, 15) == 0) ? 8'(IDX + 1) : 8'(IDX);
        step(1'b1, idx, wr, 16'($urandom), 8'($urandom));
      end
      step(1'b0, 8'(IDX), 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      idle(3);
    end

    check("a_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
